train_track_emulator: RTL and testbench

- Drives the six track-sensor lines S1..S6 that the train controller consumes; it sits at the other end of the sensor interface.
- Models one train moving along a six-sensor track, forward (S1→S6) or reverse (S6→S1).
- At each sensor the train reaches, it emits a clean, registered, single-sensor pulse.
- Used for on-board self-test and as the bench stimulus source for the controller.

---
 rtl/train_track_emulator.sv | 154 +++++++++++++++
 tb/tb_train_track_emulator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/train_track_emulator.sv
// Train track emulator: drives the six sensor lines S1..S6 as if one train
// travelled the track forward (S1->S6) or in reverse (S6->S1), producing one
// clean registered pulse per sensor, then a single-cycle done strobe.
module train_track_emulator #(
  parameter int TICKS_PER_SEGMENT = 1000,
  parameter int PULSE_TICKS       = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       dir,
  input  logic       stop,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic       S4,
  output logic       S5,
  output logic       S6,
  output logic [2:0] position,
  output logic       busy,
  output logic       done
);

  // One counter serves both the travel and the pulse phase, so it is sized
  // for the longer of the two; a width of at least one bit keeps T=P=1 legal.
  localparam int CNT_MAX = (TICKS_PER_SEGMENT > PULSE_TICKS) ? TICKS_PER_SEGMENT : PULSE_TICKS;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] TRAVEL_LAST = CW'(TICKS_PER_SEGMENT - 1);
  localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAVEL = 2'd1,
    PULSE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          dir_run;
  logic [5:0]    sensors;

  // Sensor line selected by a track position; positions outside 1..6 select none.
  function automatic logic [5:0] sensor_onehot(input logic [2:0] pos);
    logic [5:0] lines;
    lines = 6'b000000;
    case (pos)
      3'd1:    lines = 6'b000001;
      3'd2:    lines = 6'b000010;
      3'd3:    lines = 6'b000100;
      3'd4:    lines = 6'b001000;
      3'd5:    lines = 6'b010000;
      3'd6:    lines = 6'b100000;
      default: lines = 6'b000000;
    endcase
    return lines;
  endfunction

  // Last sensor of the run: S6 going forward, S1 going in reverse.
  function automatic logic at_terminal(input logic [2:0] pos, input logic rev);
    return rev ? (pos == 3'd1) : (pos == 3'd6);
  endfunction

  // Next sensor along the direction of travel.
  function automatic logic [2:0] step_position(input logic [2:0] pos, input logic rev);
    return rev ? (pos - 3'd1) : (pos + 3'd1);
  endfunction

  // Run sequencer: every output comes straight from a register so the
  // controller at the far end never sees combinational glitches.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      count    <= '0;
      dir_run  <= 1'b0;
      sensors  <= 6'b000000;
      position <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // stop held together with start keeps the emulator parked
          if (start && !stop) begin
            state    <= TRAVEL;
            dir_run  <= dir;
            position <= dir ? 3'd6 : 3'd1;
            count    <= '0;
            busy     <= 1'b1;
          end
        end

        TRAVEL: begin
          if (stop) begin
            state    <= IDLE;
            count    <= '0;
            sensors  <= 6'b000000;
            position <= 3'd0;
            busy     <= 1'b0;
          end else if (count == TRAVEL_LAST) begin
            state   <= PULSE;
            count   <= '0;
            sensors <= sensor_onehot(position);
          end else begin
            count <= count + CW'(1);
          end
        end

        PULSE: begin
          if (stop) begin
            state    <= IDLE;
            count    <= '0;
            sensors  <= 6'b000000;
            position <= 3'd0;
            busy     <= 1'b0;
          end else if (count == PULSE_LAST) begin
            sensors <= 6'b000000;
            count   <= '0;
            if (at_terminal(position, dir_run)) begin
              state    <= DONE;
              position <= 3'd0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              state    <= TRAVEL;
              position <= step_position(position, dir_run);
            end
          end else begin
            count <= count + CW'(1);
          end
        end

        DONE: begin
          // done drops via the default above; start is not looked at here
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign S1 = sensors[0];
  assign S2 = sensors[1];
  assign S3 = sensors[2];
  assign S4 = sensors[3];
  assign S5 = sensors[4];
  assign S6 = sensors[5];

endmodule

// File: tb/tb_train_track_emulator.sv
// Bench for train_track_emulator: runs are described by their start edge,
// direction and optional stop edge; expected sensor/done events are derived
// from the run timing formulas and queued, and an independent monitor pops
// and compares them as the DUT produces edges on S1..S6 and done.
module tb_train_track_emulator;

  localparam int T   = 10;
  localparam int P   = 3;
  localparam int SEG = T + P;
  localparam int RUN = 6 * SEG;
  localparam int NEVER = 1000000;

  logic       CLK;
  logic       RST;
  logic       start;
  logic       dir;
  logic       stop;
  logic       S1, S2, S3, S4, S5, S6;
  logic [2:0] position;
  logic       busy;
  logic       done;

  train_track_emulator #(
    .TICKS_PER_SEGMENT(T),
    .PULSE_TICKS(P)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .start(start),
    .dir(dir),
    .stop(stop),
    .S1(S1),
    .S2(S2),
    .S3(S3),
    .S4(S4),
    .S5(S5),
    .S6(S6),
    .position(position),
    .busy(busy),
    .done(done)
  );

  // kind: 0 = sensor rises, 1 = sensor falls, 2 = done strobe
  typedef struct {
    int kind;
    int sensor;
    int edge_n;
  } ev_t;

  ev_t exp_q[$];

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  // Current run as the reference model sees it
  int run_e0  = -NEVER;
  int run_es  = -NEVER;
  bit run_dir = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Expected events for a run starting at edge e0, optionally stopped at edge es.
  task automatic push_run(input int e0, input bit d, input int es);
    ev_t e;
    int  s, rise, fall;
    run_e0  = e0;
    run_dir = d;
    run_es  = es;
    for (int k = 1; k <= 6; k++) begin
      s    = d ? (7 - k) : k;
      rise = e0 + (k - 1) * SEG + T;
      fall = e0 + k * SEG;
      if (rise < es) begin
        e.kind = 0; e.sensor = s; e.edge_n = rise;
        exp_q.push_back(e);
        e.kind = 1; e.sensor = s; e.edge_n = (fall < es) ? fall : es;
        exp_q.push_back(e);
      end
    end
    if (e0 + RUN < es) begin
      e.kind = 2; e.sensor = 0; e.edge_n = e0 + RUN;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_event(input int kind, input int sensor, input int n);
    ev_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL event: got kind %0d sensor S%0d at edge %0d, required no event", kind, sensor, n);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.sensor != sensor || e.edge_n != n) begin
        mismatched++;
        $display("FAIL event: got kind %0d sensor S%0d edge %0d, required kind %0d sensor S%0d edge %0d",
                 kind, sensor, n, e.kind, e.sensor, e.edge_n);
      end
    end
  endtask

  // Monitor: samples on the falling edge, turns output transitions into events
  initial begin
    logic [5:0] prev_s;
    logic [5:0] cur_s;
    int run_end, k, exp_pos;
    bit exp_busy;
    prev_s = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev_s = '0;
      end else begin
        cur_s = {S6, S5, S4, S3, S2, S1};
        for (int j = 0; j < 6; j++)
          if (prev_s[j] && !cur_s[j]) check_event(1, j + 1, cyc);
        for (int j = 0; j < 6; j++)
          if (!prev_s[j] && cur_s[j]) check_event(0, j + 1, cyc);
        if (done) check_event(2, 0, cyc);
        run_end  = (run_e0 + RUN < run_es) ? run_e0 + RUN : run_es;
        exp_busy = (cyc >= run_e0) && (cyc < run_end);
        if (exp_busy) begin
          k       = (cyc - run_e0) / SEG;
          exp_pos = run_dir ? (6 - k) : (k + 1);
        end else begin
          exp_pos = 0;
        end
        chk("busy", int'(busy), int'(exp_busy));
        chk("position", int'(position), exp_pos);
        prev_s = cur_s;
      end
    end
  end

  // One run; stop_off < 0 means no stop, spur pulses start at offsets 5, 40
  // and during DONE. dir is scrambled throughout the run.
  task automatic do_run(input bit d, input int stop_off, input bit spur);
    int e0;
    @(negedge CLK);
    start = 1'b1;
    dir   = d;
    e0    = cyc + 1;
    push_run(e0, d, (stop_off < 0) ? NEVER : e0 + stop_off);
    @(negedge CLK);
    start = 1'b0;
    for (int off = 1; off <= RUN + 3; off++) begin
      start = spur && (stop_off < 0 || off < stop_off) &&
              (off == 5 || off == 40 || off == RUN + 1);
      dir   = 1'($urandom);
      stop  = (off == stop_off);
      @(negedge CLK);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    int e0;
    RST   = 1'b1;
    start = 1'b0;
    dir   = 1'b0;
    stop  = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_s", int'({S6, S5, S4, S3, S2, S1}), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_position", int'(position), 0);
    chk("reset_done", int'(done), 0);
    #2 RST = 1'b0;

    // Directed runs
    do_run(1'b0, -1, 1'b0);
    do_run(1'b1, -1, 1'b0);
    do_run(1'b0, 37, 1'b0);
    do_run(1'b0, -1, 1'b0);
    do_run(1'b0, -1, 1'b1);

    // start and stop together in IDLE must not launch a run
    @(negedge CLK);
    start = 1'b1;
    stop  = 1'b1;
    repeat (3) @(negedge CLK);
    start = 1'b0;
    stop  = 1'b0;
    repeat (100) @(negedge CLK);

    // Asynchronous reset while S4 is high
    @(negedge CLK);
    start = 1'b1;
    dir   = 1'b0;
    e0    = cyc + 1;
    push_run(e0, 1'b0, NEVER);
    @(negedge CLK);
    start = 1'b0;
    repeat (49) @(negedge CLK);
    chk("s4_before_reset", int'(S4), 1);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    exp_q.delete();
    run_es = cyc;
    #1;
    chk("async_reset_s", int'({S6, S5, S4, S3, S2, S1}), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_position", int'(position), 0);
    @(negedge CLK);
    #2 RST = 1'b0;
    do_run(1'b0, -1, 1'b0);

    // Randomised runs
    for (int r = 0; r < 14; r++) begin
      do_run(1'($urandom), ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, RUN + 2)),
             1'($urandom));
    end

    repeat (5) @(negedge CLK);
    chk("pending_events", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
